// File: rtl/jtcop_sndcomm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jtcop_sndcomm_if : bus bundle between the main CPU decoder side and the
//                    sound command channel / vblank IRQ block.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface jtcop_sndcomm_if;
    logic       snreq;
    logic       RnW;
    logic [7:0] cpu_dout;
    logic       snd_latch_rd;
    logic       LVBL;
    logic       LVBL_l;
    logic       vint_clr;
    logic       cpu_iack;
    logic [7:0] snd_latch;
    logic       snd_nmin;
    logic       pending;
    logic       overrun;
    logic       cpu_ipl6n;

    modport master (
        output snreq, RnW, cpu_dout, snd_latch_rd, LVBL, LVBL_l, vint_clr, cpu_iack,
        input  snd_latch, snd_nmin, pending, overrun, cpu_ipl6n
    );

    modport slave (
        input  snreq, RnW, cpu_dout, snd_latch_rd, LVBL, LVBL_l, vint_clr, cpu_iack,
        output snd_latch, snd_nmin, pending, overrun, cpu_ipl6n
    );
endinterface
`default_nettype wire

// File: rtl/jtcop_sndcomm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jtcop_sndcomm : 68000->6502 sound command latch with NMI pulse and
//                 handshake status, plus the 68000 level-6 vblank IRQ.
// Revision: 1.0
// ---------------------------------------------------------------------------
module jtcop_sndcomm #(
    parameter int unsigned NMI_LEN = 16
) (
    input  logic            clk,
    input  logic            rst,
    jtcop_sndcomm_if.slave  bus_io
);
    localparam logic [7:0] C_NMI_LEN = 8'(NMI_LEN);

    logic       wr_l_q;
    logic       rd_l_q;
    logic [7:0] nmi_cnt_q;
    logic [7:0] nmi_cnt_d;
    logic [7:0] latch_q;
    logic       nmin_q;
    logic       pending_q;
    logic       overrun_q;
    logic       ipl6n_q;

    logic       wr_req;
    logic       wr_ev;
    logic       rd_ev;
    logic       vb_ev;
    logic       irq_clr;

    assign wr_req  = bus_io.snreq & ~bus_io.RnW;
    assign wr_ev   = wr_req & ~wr_l_q;
    assign rd_ev   = bus_io.snd_latch_rd & ~rd_l_q;
    assign vb_ev   = ~bus_io.LVBL & bus_io.LVBL_l;
    assign irq_clr = bus_io.vint_clr | bus_io.cpu_iack;

    // A write reloads the counter, so a pulse in flight is stretched, never split
    always_comb begin
        nmi_cnt_d = (nmi_cnt_q != 8'd0) ? nmi_cnt_q - 8'd1 : 8'd0;
        if (wr_ev) begin
            nmi_cnt_d = C_NMI_LEN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Edge registers held high so a cycle straddling reset release is not an event
            wr_l_q    <= 1'b1;
            rd_l_q    <= 1'b1;
            nmi_cnt_q <= 8'd0;
            latch_q   <= 8'h00;
            nmin_q    <= 1'b1;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            ipl6n_q   <= 1'b1;
        end else begin
            wr_l_q    <= wr_req;
            rd_l_q    <= bus_io.snd_latch_rd;
            nmi_cnt_q <= nmi_cnt_d;
            nmin_q    <= (nmi_cnt_d == 8'd0);

            if (wr_ev) begin
                latch_q   <= bus_io.cpu_dout;
                pending_q <= 1'b1;
                if (pending_q && !rd_ev) begin
                    overrun_q <= 1'b1;
                end
            end else if (rd_ev) begin
                pending_q <= 1'b0;
                overrun_q <= 1'b0;
            end

            if (vb_ev) begin
                ipl6n_q <= 1'b0;
            end else if (irq_clr) begin
                ipl6n_q <= 1'b1;
            end
        end
    end

    assign bus_io.snd_latch = latch_q;
    assign bus_io.snd_nmin  = nmin_q;
    assign bus_io.pending   = pending_q;
    assign bus_io.overrun   = overrun_q;
    assign bus_io.cpu_ipl6n = ipl6n_q;
endmodule
`default_nettype wire

// File: tb/tb_jtcop_sndcomm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jtcop_sndcomm : directed stimulus with a cycle-tagged expectation queue
//                    drained by an independent negedge monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_jtcop_sndcomm;
    localparam int C_SIG_LATCH   = 0;
    localparam int C_SIG_NMIN    = 1;
    localparam int C_SIG_PENDING = 2;
    localparam int C_SIG_OVERRUN = 3;
    localparam int C_SIG_IPL6N   = 4;
    localparam int C_SIG_FALLS   = 5;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   falls;
    int   exp_falls;
    bit   prev_nmin;
    int   checks;
    int   errors;
    exp_t sb[$];

    jtcop_sndcomm_if bus();

    jtcop_sndcomm #(.NMI_LEN(16)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(posedge clk) bus.LVBL_l <= bus.LVBL;

    // Keep the queue ordered by target cycle
    function automatic void expect_at(int at, int sig, int val, string name);
        exp_t e;
        int   i;
        e.cyc  = at;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= at) i++;
        sb.insert(i, e);
    endfunction

    function automatic logic [31:0] sample(int sig);
        case (sig)
            C_SIG_LATCH:   return {24'd0, bus.snd_latch};
            C_SIG_NMIN:    return {31'd0, bus.snd_nmin};
            C_SIG_PENDING: return {31'd0, bus.pending};
            C_SIG_OVERRUN: return {31'd0, bus.overrun};
            C_SIG_IPL6N:   return {31'd0, bus.cpu_ipl6n};
            default:       return falls;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (prev_nmin && bus.snd_nmin === 1'b0) falls++;
        prev_nmin = (bus.snd_nmin === 1'b1);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = sample(e.sig);
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: stale expectation for cycle %0d at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_start(logic [7:0] d);
        bus.snreq    = 1'b1;
        bus.RnW      = 1'b0;
        bus.cpu_dout = d;
    endtask

    task automatic write_end();
        bus.snreq = 1'b0;
        bus.RnW   = 1'b1;
    endtask

    initial begin
        int c;
        int guard;
        clk = 1'b0; cyc = 0; falls = 0; exp_falls = 0; prev_nmin = 1'b1;
        checks = 0; errors = 0;
        rst = 1'b1;
        bus.snreq = 1'b1; bus.RnW = 1'b0; bus.cpu_dout = 8'h5A;
        bus.snd_latch_rd = 1'b0; bus.LVBL = 1'b1; bus.vint_clr = 1'b0; bus.cpu_iack = 1'b0;
        tick(3);

        // Reset state, then release with a write cycle already asserted
        c = cyc;
        expect_at(c, C_SIG_LATCH, 8'h00, "rst_latch");
        expect_at(c, C_SIG_NMIN, 1, "rst_nmin");
        expect_at(c, C_SIG_PENDING, 0, "rst_pending");
        expect_at(c, C_SIG_OVERRUN, 0, "rst_overrun");
        expect_at(c, C_SIG_IPL6N, 1, "rst_ipl6n");
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            expect_at(c + k, C_SIG_NMIN, 1, "held_nmin");
            expect_at(c + k, C_SIG_PENDING, 0, "held_pending");
        end
        tick(20);
        write_end();
        tick(2);

        // Long write: one event, 16-cycle NMI
        c = cyc;
        write_start(8'hA5);
        expect_at(c + 1, C_SIG_LATCH, 8'hA5, "wrA5_latch");
        expect_at(c + 1, C_SIG_PENDING, 1, "wrA5_pending");
        for (int k = 1; k <= 16; k++) expect_at(c + k, C_SIG_NMIN, 0, "wrA5_nmin_low");
        expect_at(c + 17, C_SIG_NMIN, 1, "wrA5_nmin_end");
        exp_falls++;
        expect_at(c + 17, C_SIG_FALLS, exp_falls, "wrA5_falls");
        tick(6);
        write_end();
        tick(14);
        c = cyc;
        bus.snd_latch_rd = 1'b1;
        expect_at(c + 1, C_SIG_PENDING, 0, "rd1_pending");
        tick(2);
        bus.snd_latch_rd = 1'b0;
        tick(2);

        // Overrun: second write 8 cycles later stretches the pulse to 24 cycles
        c = cyc;
        write_start(8'h11);
        expect_at(c + 1, C_SIG_LATCH, 8'h11, "wr11_latch");
        expect_at(c + 1, C_SIG_PENDING, 1, "wr11_pending");
        for (int k = 1; k <= 24; k++) expect_at(c + k, C_SIG_NMIN, 0, "ovr_nmin_low");
        expect_at(c + 25, C_SIG_NMIN, 1, "ovr_nmin_end");
        exp_falls++;
        expect_at(c + 25, C_SIG_FALLS, exp_falls, "ovr_falls");
        expect_at(c + 8, C_SIG_OVERRUN, 0, "ovr_before");
        expect_at(c + 9, C_SIG_OVERRUN, 1, "ovr_set");
        expect_at(c + 9, C_SIG_LATCH, 8'h22, "wr22_latch");
        tick(2);
        write_end();
        tick(6);
        write_start(8'h22);
        tick(2);
        write_end();
        tick(20);
        c = cyc;
        bus.snd_latch_rd = 1'b1;
        expect_at(c + 1, C_SIG_PENDING, 0, "rd2_pending");
        expect_at(c + 1, C_SIG_OVERRUN, 0, "rd2_overrun");
        tick(3);
        bus.snd_latch_rd = 1'b0;
        tick(1);

        // Write and read events in the same cycle with pending already set
        c = cyc;
        write_start(8'h44);
        expect_at(c + 1, C_SIG_PENDING, 1, "wr44_pending");
        tick(2);
        write_end();
        tick(2);
        c = cyc;
        write_start(8'h33);
        bus.snd_latch_rd = 1'b1;
        expect_at(c + 1, C_SIG_PENDING, 1, "wrrd_pending");
        expect_at(c + 1, C_SIG_OVERRUN, 0, "wrrd_overrun");
        expect_at(c + 1, C_SIG_LATCH, 8'h33, "wrrd_latch");
        tick(2);
        write_end();
        bus.snd_latch_rd = 1'b0;
        tick(20);
        exp_falls++;
        expect_at(cyc, C_SIG_FALLS, exp_falls, "wrrd_falls");
        c = cyc;
        bus.snd_latch_rd = 1'b1;
        expect_at(c + 1, C_SIG_PENDING, 0, "rd3_pending");
        tick(2);
        bus.snd_latch_rd = 1'b0;
        tick(1);

        // Vblank interrupt: set, clear, set-wins collision, iack clear
        c = cyc;
        bus.LVBL = 1'b0;
        expect_at(c, C_SIG_IPL6N, 1, "vb_idle");
        expect_at(c + 1, C_SIG_IPL6N, 0, "vb_set");
        expect_at(c + 3, C_SIG_IPL6N, 0, "vb_hold");
        expect_at(c + 4, C_SIG_IPL6N, 1, "vb_clr");
        tick(3);
        bus.vint_clr = 1'b1;
        tick(1);
        bus.vint_clr = 1'b0;
        tick(2);
        bus.LVBL = 1'b1;
        tick(2);
        c = cyc;
        bus.LVBL = 1'b0;
        bus.cpu_iack = 1'b1;
        expect_at(c + 1, C_SIG_IPL6N, 0, "vb_setwins");
        expect_at(c + 2, C_SIG_IPL6N, 0, "vb_setwins_hold");
        tick(1);
        bus.cpu_iack = 1'b0;
        tick(2);
        c = cyc;
        bus.cpu_iack = 1'b1;
        expect_at(c + 1, C_SIG_IPL6N, 1, "vb_iack_clr");
        tick(1);
        bus.cpu_iack = 1'b0;
        bus.LVBL = 1'b1;
        tick(2);

        // Reset while the NMI counter holds 9
        c = cyc;
        write_start(8'h77);
        expect_at(c + 1, C_SIG_LATCH, 8'h77, "wr77_latch");
        expect_at(c + 8, C_SIG_NMIN, 0, "prerst_nmin");
        expect_at(c + 9, C_SIG_NMIN, 1, "midrst_nmin");
        expect_at(c + 9, C_SIG_PENDING, 0, "midrst_pending");
        expect_at(c + 9, C_SIG_LATCH, 8'h00, "midrst_latch");
        expect_at(c + 9, C_SIG_OVERRUN, 0, "midrst_overrun");
        expect_at(c + 9, C_SIG_IPL6N, 1, "midrst_ipl6n");
        exp_falls++;
        tick(2);
        write_end();
        tick(6);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        expect_at(cyc, C_SIG_FALLS, exp_falls, "final_falls");

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            tick(1);
            guard++;
        end
        if (sb.size() > 0) begin
            errors += sb.size();
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
